// File: rtl/bdd_eval_pkg.sv
`default_nettype none
// ============================================================================
// Module : bdd_eval_pkg
// Brief  : Shared widths, tag-width helper and request record for the
//          BDD evaluation arbiter and its agents.
// Rev    : 1.0  initial release
// ============================================================================
package bdd_eval_pkg;

    localparam int c_fn_in_w  = 12;
    localparam int c_fn_out_w = 9;
    localparam int c_max_id_w = 3;

    // Minimum tag width able to index n requesters (never below one bit).
    function automatic int id_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    typedef struct packed {
        logic [c_fn_in_w-1:0]  data;
        logic [c_max_id_w-1:0] id;
    } bdd_req_t;

endpackage
`default_nettype wire

// File: rtl/bdd_eval_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin grant; the first valid index at or
//          after i_ptr (wrapping) wins.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    i_valid,
    input  logic [ID_W-1:0] i_ptr,
    output logic [N-1:0]    o_grant,
    output logic [ID_W-1:0] o_grant_idx,
    output logic            o_grant_any
);

    int w_ptr;
    int w_best_idx;
    int w_best_dist;

    // Distance from the pointer, modulo N; the smallest distance wins.
    always_comb begin
        w_ptr       = int'(i_ptr);
        w_best_idx  = 0;
        w_best_dist = N;
        for (int j = 0; j < N; j++) begin
            if (i_valid[j] && ((j - w_ptr + ((j < w_ptr) ? N : 0)) < w_best_dist)) begin
                w_best_dist = j - w_ptr + ((j < w_ptr) ? N : 0);
                w_best_idx  = j;
            end
        end
    end

    always_comb begin
        o_grant = '0;
        for (int j = 0; j < N; j++) begin
            o_grant[j] = (w_best_dist < N) && (w_best_idx == j);
        end
    end

    assign o_grant_idx = ID_W'(w_best_idx);
    assign o_grant_any = (w_best_dist < N);

endmodule
`default_nettype wire

// File: rtl/bdd_eval_arbiter.sv
`default_nettype none
// ============================================================================
// Module : bdd_eval_arbiter
// Brief  : Round-robin sharing of one external BDD function among NUM_REQ
//          requesters through a two-stage registered pipeline with tags.
// Rev    : 1.0  initial release
// ============================================================================
module bdd_eval_arbiter
    import bdd_eval_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = c_fn_in_w,
    parameter int OUT_W   = c_fn_out_w,
    parameter int ID_W    = id_width(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [IN_W-1:0]         fn_in,
    input  logic [OUT_W-1:0]        fn_out,
    output logic                    rsp_valid,
    output logic [OUT_W-1:0]        rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    input  logic                    rsp_ready,
    output logic [CNT_W-1:0]        eval_count,
    output logic                    busy
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic              r_s1_v;
    logic [IN_W-1:0]   r_s1_data;
    logic [ID_W-1:0]   r_s1_id;
    logic              r_s2_v;
    logic [OUT_W-1:0]  r_rsp_data;
    logic [ID_W-1:0]   r_rsp_id;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]  r_eval_count;

    logic [IN_W-1:0]    w_ops [NUM_REQ];
    logic [IN_W-1:0]    w_sel_data;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_grant_any;
    logic               w_s1_load;
    logic               w_s2_load;
    logic               w_accept;
    logic [ID_W-1:0]    w_ptr_next;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_ops
        assign w_ops[k] = req_data[k*IN_W +: IN_W];
    end

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .i_valid     (req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_any (w_grant_any)
    );

    always_comb begin
        w_sel_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_grant[j]) w_sel_data = w_sel_data | w_ops[j];
        end
    end

    // S1 may refill in the same cycle S2 drains, giving one result per cycle.
    assign w_s2_load  = r_s1_v && (!r_s2_v || rsp_ready);
    assign w_s1_load  = !r_s1_v || w_s2_load;
    assign w_accept   = w_s1_load && !rst && w_grant_any;
    assign req_ready  = (w_s1_load && !rst) ? w_grant : '0;
    assign w_ptr_next = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v       <= 1'b0;
            r_s1_data    <= '0;
            r_s1_id      <= '0;
            r_s2_v       <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_id     <= '0;
            r_rr_ptr     <= '0;
            r_eval_count <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_v <= w_accept;
                if (w_accept) begin
                    r_s1_data <= w_sel_data;
                    r_s1_id   <= w_grant_idx;
                    r_rr_ptr  <= w_ptr_next;
                end
            end
            if (w_s2_load) begin
                r_s2_v     <= 1'b1;
                r_rsp_data <= fn_out;
                r_rsp_id   <= r_s1_id;
            end else if (r_s2_v && rsp_ready) begin
                r_s2_v <= 1'b0;
            end
            if (r_s2_v && rsp_ready && (r_eval_count != c_cnt_max)) begin
                r_eval_count <= r_eval_count + CNT_W'(1);
            end
        end
    end

    assign fn_in      = r_s1_data;
    assign rsp_valid  = r_s2_v;
    assign rsp_data   = r_rsp_data;
    assign rsp_id     = r_rsp_id;
    assign eval_count = r_eval_count;
    assign busy       = r_s1_v || r_s2_v;

endmodule
`default_nettype wire
